// File: rtl/led_bar_monitor.sv
// led_bar_monitor: passive observer for the LED flasher bar.
// Decodes thermometer level, tracks direction, flags bad samples.
//
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   LEDs         : observed bar pattern, bit 0 lights first
//   clr          : sync clear of err_count and cycle_count
//   level        : lit-LED count of last valid sample
//   dir          : 00 IDLE, 01 UP, 10 DOWN
//   turn_pulse   : UP<->DOWN reversal pulse
//   turn_level   : level at last reversal (peak/trough)
//   cycle_done   : pulse on DOWN reaching 0
//   cycle_count  : completed cycles, wraps
//   err_code     : pulse on non-thermometer sample
//   err_step     : pulse on |delta level| > MAX_STEP
//   err_count    : saturating error event count
module led_bar_monitor #(
  parameter int WIDTH    = 16,
  parameter int MAX_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] LEDs,
  input  logic             clr,
  output logic [4:0]       level,
  output logic [1:0]       dir,
  output logic             turn_pulse,
  output logic [4:0]       turn_level,
  output logic             cycle_done,
  output logic [7:0]       cycle_count,
  output logic             err_code,
  output logic             err_step,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ONE = 1;

  state_t            state, state_d;
  logic [WIDTH-1:0]  leds_q;
  logic              code_ok;
  logic [4:0]        new_lvl;
  logic signed [5:0] delta;
  logic [5:0]        mag;
  logic              step_big;
  logic              go_up, go_dn;
  logic [4:0]        level_d, turn_level_d;
  logic              turn_d, done_d;
  logic              ecode_d, estep_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) leds_q <= '0;
    else        leds_q <= LEDs;
  end

  // (2^n)-1 has no bit in common with its successor
  assign code_ok = ((leds_q & (leds_q + ONE)) == '0);

  always_comb begin
    new_lvl = '0;
    for (int i = 0; i < WIDTH; i++)
      new_lvl = new_lvl + 5'(leds_q[i]);
  end

  assign delta    = $signed({1'b0, new_lvl})
                  - $signed({1'b0, level});
  assign mag      = delta[5] ? 6'(-delta) : 6'(delta);
  assign step_big = (mag > 6'(MAX_STEP));
  assign go_up    = !delta[5] && (delta != 6'sd0);
  assign go_dn    = delta[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d      = state;
    level_d      = level;
    turn_level_d = turn_level;
    turn_d       = 1'b0;
    done_d       = 1'b0;
    ecode_d      = 1'b0;
    estep_d      = 1'b0;
    if (!code_ok) begin
      // bad sample: everything holds
      ecode_d = 1'b1;
    end else begin
      level_d = new_lvl;
      estep_d = step_big;
      unique case (state)
        IDLE: begin
          if (go_up)      state_d = UP;
          else if (go_dn) state_d = DOWN;
        end
        UP: begin
          if (go_dn) begin
            state_d      = DOWN;
            turn_d       = 1'b1;
            turn_level_d = level;
          end
        end
        DOWN: begin
          if (go_up) begin
            state_d      = UP;
            turn_d       = 1'b1;
            turn_level_d = level;
          end else if (go_dn && new_lvl == 5'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dir = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= '0;
      turn_level <= '0;
      turn_pulse <= 1'b0;
      cycle_done <= 1'b0;
      err_code   <= 1'b0;
      err_step   <= 1'b0;
    end else begin
      level      <= level_d;
      turn_level <= turn_level_d;
      turn_pulse <= turn_d;
      cycle_done <= done_d;
      err_code   <= ecode_d;
      err_step   <= estep_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      err_count   <= '0;
    end else if (clr) begin
      cycle_count <= '0;
      err_count   <= '0;
    end else begin
      if (done_d)
        cycle_count <= cycle_count + 8'd1;
      if ((ecode_d || estep_d) && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_led_bar_monitor.sv
// tb_led_bar_monitor: scoreboard bench for led_bar_monitor.
// Model predicts every sample; outputs checked two edges later.
module tb_led_bar_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] LEDs = '0;
  logic [4:0]  level, turn_level;
  logic [1:0]  dir;
  logic        turn_pulse, cycle_done;
  logic        err_code, err_step;
  logic [7:0]  cycle_count, err_count;

  led_bar_monitor #(.WIDTH(16), .MAX_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .LEDs(LEDs), .clr(clr),
    .level(level), .dir(dir),
    .turn_pulse(turn_pulse), .turn_level(turn_level),
    .cycle_done(cycle_done), .cycle_count(cycle_count),
    .err_code(err_code), .err_step(err_step),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] lvl;
    logic [1:0] dr;
    logic       tp;
    logic [4:0] tl;
    logic       cd;
    logic [7:0] cc;
    logic       ec;
    logic       es;
    logic [7:0] ecnt;
  } exp_t;

  exp_t q[$];

  int m_lvl, m_tl, m_cc, m_ec;
  logic [1:0] m_dir;
  int checks, errors;
  int obs_turn, obs_done, obs_ec, obs_es;
  int lvl_at_ec;
  int tl_seen[$];
  logic [1:0] dir_seq[$];
  logic [1:0] prev_dir;

  task automatic model_push(input logic [15:0] v);
    exp_t e;
    int n, d;
    n = -1;
    for (int k = 0; k <= 16; k++)
      if (int'(v) == (1 << k) - 1) n = k;
    e = '0;
    if (n < 0) begin
      e.ec = 1'b1;
      if (m_ec < 255) m_ec++;
    end else begin
      d = n - m_lvl;
      if (d > 1 || d < -1) begin
        e.es = 1'b1;
        if (m_ec < 255) m_ec++;
      end
      case (m_dir)
        2'b00: begin
          if (d > 0) m_dir = 2'b01;
          else if (d < 0) m_dir = 2'b10;
        end
        2'b01: begin
          if (d < 0) begin
            m_dir = 2'b10; e.tp = 1'b1; m_tl = m_lvl;
          end
        end
        default: begin
          if (d > 0) begin
            m_dir = 2'b01; e.tp = 1'b1; m_tl = m_lvl;
          end else if (d < 0 && n == 0) begin
            m_dir = 2'b00; e.cd = 1'b1;
            m_cc = (m_cc + 1) % 256;
          end
        end
      endcase
      m_lvl = n;
    end
    e.lvl  = 5'(m_lvl);
    e.dr   = m_dir;
    e.tl   = 5'(m_tl);
    e.cc   = 8'(m_cc);
    e.ecnt = 8'(m_ec);
    q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    e = q.pop_front();
    checks += 9;
    if (level !== e.lvl) begin
      errors++;
      $display("FAIL level got %0d exp %0d", level, e.lvl);
    end
    if (dir !== e.dr) begin
      errors++;
      $display("FAIL dir got %0b exp %0b", dir, e.dr);
    end
    if (turn_pulse !== e.tp) begin
      errors++;
      $display("FAIL turn_pulse got %0b exp %0b",
               turn_pulse, e.tp);
    end
    if (turn_level !== e.tl) begin
      errors++;
      $display("FAIL turn_level got %0d exp %0d",
               turn_level, e.tl);
    end
    if (cycle_done !== e.cd) begin
      errors++;
      $display("FAIL cycle_done got %0b exp %0b",
               cycle_done, e.cd);
    end
    if (cycle_count !== e.cc) begin
      errors++;
      $display("FAIL cycle_count got %0d exp %0d",
               cycle_count, e.cc);
    end
    if (err_code !== e.ec) begin
      errors++;
      $display("FAIL err_code got %0b exp %0b",
               err_code, e.ec);
    end
    if (err_step !== e.es) begin
      errors++;
      $display("FAIL err_step got %0b exp %0b",
               err_step, e.es);
    end
    if (err_count !== e.ecnt) begin
      errors++;
      $display("FAIL err_count got %0d exp %0d",
               err_count, e.ecnt);
    end
    if (turn_pulse === 1'b1) begin
      obs_turn++;
      tl_seen.push_back(int'(turn_level));
    end
    if (cycle_done === 1'b1) obs_done++;
    if (err_code === 1'b1) begin
      obs_ec++;
      lvl_at_ec = int'(level);
    end
    if (err_step === 1'b1) obs_es++;
    if (dir !== prev_dir) dir_seq.push_back(dir);
    prev_dir = dir;
  endtask

  task automatic drive(input logic [15:0] v,
                       input logic c = 1'b0);
    exp_t e;
    @(negedge clk);
    if (q.size() >= 2) sb_check();
    clr = c;
    if (c) begin
      // clear lands with the sample already in flight
      m_cc = 0;
      m_ec = 0;
      if (q.size() > 0) begin
        e = q.pop_back();
        e.cc = '0;
        e.ecnt = '0;
        q.push_back(e);
      end
    end
    LEDs = v;
    model_push(v);
  endtask

  task automatic flush();
    drive(LEDs);
    drive(LEDs);
  endtask

  task automatic clear_obs();
    obs_turn = 0; obs_done = 0;
    obs_ec = 0; obs_es = 0;
    lvl_at_ec = -1;
    tl_seen.delete();
    dir_seq.delete();
    prev_dir = dir;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({level, dir, turn_pulse, turn_level, cycle_done,
         cycle_count, err_code, err_step, err_count}
        !== '0) begin
      errors++;
      $display("FAIL %s got lvl=%0d dir=%0b tp=%0b tl=%0d cd=%0b cc=%0d ec=%0b es=%0b ecnt=%0d exp all 0",
               tag, level, dir, turn_pulse, turn_level,
               cycle_done, cycle_count, err_code, err_step,
               err_count);
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    q.delete();
    m_lvl = 0; m_tl = 0; m_cc = 0; m_ec = 0;
    m_dir = 2'b00;
    // register still holds its reset zero for one edge
    model_push(16'h0000);
    model_push(LEDs);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    LEDs = '0;
    clr = 1'b0;
    #10;
    check_zero("reset_state");
    release_reset();
    clear_obs();
    for (int i = 0; i < 20; i++) drive(16'h0000);
    flush();
    checks++;
    if (obs_turn + obs_done + obs_ec + obs_es != 0) begin
      errors++;
      $display("FAIL idle_pulses got %0d exp 0",
               obs_turn + obs_done + obs_ec + obs_es);
    end
  endtask

  task automatic test_sweep();
    clear_obs();
    for (int i = 1; i <= 16; i++)
      drive(16'((32'd1 << i) - 1));
    for (int i = 15; i >= 0; i--)
      drive(16'((32'd1 << i) - 1));
    flush();
    checks += 4;
    if (obs_turn != 1 || tl_seen.size() != 1) begin
      errors++;
      $display("FAIL sweep_turns got %0d exp 1", obs_turn);
    end else if (tl_seen[0] != 16) begin
      errors++;
      $display("FAIL sweep_peak got %0d exp 16", tl_seen[0]);
    end
    if (obs_done != 1) begin
      errors++;
      $display("FAIL sweep_done got %0d exp 1", obs_done);
    end
    if (cycle_count !== 8'd1) begin
      errors++;
      $display("FAIL sweep_cycles got %0d exp 1", cycle_count);
    end
    if (obs_ec + obs_es != 0) begin
      errors++;
      $display("FAIL sweep_errs got %0d exp 0",
               obs_ec + obs_es);
    end
  endtask

  task automatic test_kickback();
    clear_obs();
    for (int i = 1; i <= 10; i++)
      drive(16'((32'd1 << i) - 1));
    for (int i = 9; i >= 5; i--)
      drive(16'((32'd1 << i) - 1));
    for (int i = 6; i <= 16; i++)
      drive(16'((32'd1 << i) - 1));
    flush();
    checks += 2;
    if (tl_seen.size() != 2) begin
      errors++;
      $display("FAIL kick_turns got %0d exp 2", tl_seen.size());
    end else if (tl_seen[0] != 10 || tl_seen[1] != 5) begin
      errors++;
      $display("FAIL kick_levels got %0d,%0d exp 10,5",
               tl_seen[0], tl_seen[1]);
    end
    if (dir_seq.size() != 3) begin
      errors++;
      $display("FAIL kick_dirs got %0d changes exp 3",
               dir_seq.size());
    end else if (dir_seq[0] != 2'b01 || dir_seq[1] != 2'b10
                 || dir_seq[2] != 2'b01) begin
      errors++;
      $display("FAIL kick_dirs got %0b,%0b,%0b exp 1,10,1",
               dir_seq[0], dir_seq[1], dir_seq[2]);
    end
  endtask

  task automatic test_malformed();
    for (int i = 15; i >= 2; i--)
      drive(16'((32'd1 << i) - 1));
    clear_obs();
    drive(16'h0005);
    drive(16'h0007);
    flush();
    checks += 4;
    if (obs_ec != 1) begin
      errors++;
      $display("FAIL bad_code got %0d exp 1", obs_ec);
    end
    if (lvl_at_ec != 2) begin
      errors++;
      $display("FAIL bad_hold got %0d exp 2", lvl_at_ec);
    end
    if (obs_es != 0) begin
      errors++;
      $display("FAIL bad_step got %0d exp 0", obs_es);
    end
    if (err_count !== 8'd1) begin
      errors++;
      $display("FAIL bad_count got %0d exp 1", err_count);
    end
  endtask

  task automatic test_jump_sat();
    drive(16'h0003);
    drive(16'h0001);
    clear_obs();
    drive(16'h00FF);
    flush();
    checks += 2;
    if (obs_es != 1) begin
      errors++;
      $display("FAIL jump_step got %0d exp 1", obs_es);
    end
    if (level !== 5'd8 || dir !== 2'b01) begin
      errors++;
      $display("FAIL jump_state got lvl=%0d dir=%0b exp 8/01",
               level, dir);
    end
    for (int i = 0; i < 300; i++)
      drive((i % 2) ? 16'hFFFF : 16'h0000);
    flush();
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_count got %0d exp 255", err_count);
    end
    drive(LEDs, 1'b1);
    flush();
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL clr_count got %0d exp 0", err_count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 15; i >= 0; i--)
      drive(16'((32'd1 << i) - 1));
    for (int i = 1; i <= 9; i++)
      drive(16'((32'd1 << i) - 1));
    flush();
    @(negedge clk);
    rst_n = 1'b0;
    LEDs = 16'h01FF;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    check_zero("mid_reset_hold");
    release_reset();
    clear_obs();
    drive(16'h01FF);
    drive(16'h01FF);
    flush();
    checks++;
    if (obs_es != 1) begin
      errors++;
      $display("FAIL mid_step got %0d exp 1", obs_es);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sweep();
    test_kickback();
    test_malformed();
    test_jump_sat();
    test_reset_mid();
    while (q.size() > 0) begin
      @(negedge clk);
      sb_check();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_bar_monitor.md
# led_bar_monitor

Passive reader for the 16-LED flasher bar output. Samples the bar every clock, decodes the thermometer pattern into a lit-LED count, tracks direction of travel, and flags malformed patterns or over-large jumps. Sits beside the flasher in the design and in benches as a self-checking observer. It drives nothing back into the flasher.

## Interface
- `WIDTH`, default 16: number of LED lines observed.
- `MAX_STEP`, default 1: largest legal change in `level` per sample.
- `clk`, input, 1: rising-edge clock, the same clock as the flasher.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `LEDs`, input, WIDTH: bar pattern under observation. Bit 0 is the first LED lit.
- `clr`, input, 1: synchronous clear of `err_count` and `cycle_count` only.
- `level`, output, 5: number of lit LEDs in the last valid sample, 0..16.
- `dir`, output, 2: direction of travel. 00 = IDLE, 01 = UP, 10 = DOWN. 11 never occurs.
- `turn_pulse`, output, 1: one-cycle pulse on an UP↔DOWN reversal.
- `turn_level`, output, 5: `level` value at the most recent reversal. Holds between reversals.
- `cycle_done`, output, 1: one-cycle pulse when the bar returns to 0 from DOWN.
- `cycle_count`, output, 8: number of completed cycles. Wraps 255→0.
- `err_code`, output, 1: one-cycle pulse when a sample is not a thermometer code.
- `err_step`, output, 1: one-cycle pulse when |Δlevel| > MAX_STEP.
- `err_count`, output, 8: `err_code` + `err_step` events. Saturates at 255.

## Operation
- **Stage 1**
  - `LEDs` is registered into `leds_q` on every edge.
  - `leds_q` is a valid thermometer code iff it equals (1<<n)-1 for some n in 0..WIDTH.
  - For a valid code, `new_lvl` = n, computed as 5-bit unsigned.
- **Stage 2, invalid code**
  - Pulse `err_code` and increment `err_count`.
  - `level`, `dir`, `turn_level` and the FSM hold.
  - No step check is made, so `err_code` and `err_step` are never asserted together.
- **Stage 2, valid code**
  - Compute Δ = `new_lvl` − `level` as 6-bit signed.
  - If |Δ| > MAX_STEP: pulse `err_step`, increment `err_count`, and still update `level` and the FSM.
  - `level` ← `new_lvl`.
- **FSM states**: IDLE, UP, DOWN.
- **IDLE**
  - Δ>0 → UP.
  - Δ<0 is impossible, since IDLE implies level 0 after reset. If it occurs → DOWN.
  - Δ=0 → stay.
- **UP**
  - Δ>0 or Δ=0 → stay.
  - Δ<0 → DOWN. Pulse `turn_pulse`; `turn_level` ← old `level` (the peak).
- **DOWN**
  - Δ<0 and `new_lvl`=0 → IDLE. Pulse `cycle_done` and increment `cycle_count`. No `turn_pulse`.
  - Δ<0 and `new_lvl`>0 → stay.
  - Δ=0 → stay.
  - Δ>0 → UP. Pulse `turn_pulse`; `turn_level` ← old `level` (the trough).
- **Counters**
  - `err_count` saturates: it stays at 255 on further errors.
  - `cycle_count` wraps.
  - `clr` zeroes both counters. If a counter event coincides with `clr`, `clr` wins and the counter is 0.
  - `clr` does not affect the FSM, `level` or the pulses.
- **`dir`** is a direct encoding of the FSM state.

## Timing
- **Latency**
  - A pattern present on `LEDs` at rising edge N is captured into `leds_q` at edge N.
  - Outputs reflect that sample after edge N+1.
  - Total: 2 edges from input change to output.
- **Pulses**: all pulses (`turn_pulse`, `cycle_done`, `err_code`, `err_step`) are high for exactly one cycle per offending or qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- **Reset**
  - `rst_n` low immediately clears `leds_q` to 0.
  - It also sets `level`=0, `dir`=IDLE, `turn_level`=0, all pulses 0, `cycle_count`=0, `err_count`=0.
  - It is asynchronous to the clock.
- **Reset mid-cycle**
  - The state is discarded.
  - The first sample after release is compared against `level`=0, so a nonzero bar on release gives Δ>0.
  - If that Δ exceeds MAX_STEP, `err_step` fires.
- **Bar held constant**: no pulses; `dir` holds its last value (UP or DOWN), not IDLE, except at level 0 from reset.

## Test plan
- **Reset and idle**
  - Stimulus: `rst_n`=0 for 10 ns, then release with `LEDs`=0 for 20 cycles.
  - Required: `level`=0, `dir`=00, all pulses and counters 0 throughout.
- **Full sweep**
  - Stimulus: `LEDs` steps 0x0000→0x0001→…→0xFFFF (one bit per cycle), then back down to 0x0000.
  - Required: `dir`=01 during the rise.
  - Required: one `turn_pulse` with `turn_level`=16, two edges after the first 0x7FFF.
  - Required: `cycle_done` pulse and `cycle_count`=1 when level reaches 0.
  - Required: no errors.
- **Kickback**
  - Stimulus: rise to 0x03FF (level 10), fall to 0x001F (5), rise to 0xFFFF.
  - Required: two `turn_pulse`s, with `turn_level`=10 then 5.
  - Required: `dir` sequence UP, DOWN, UP.
- **Malformed code**
  - Stimulus: `LEDs`=0x0005 for one cycle between levels 2 and 3.
  - Required: `err_code` pulse, `level` held at 2, `err_count`=1, no `err_step`.
- **Jump and saturation**
  - Stimulus: 0x0001→0x00FF.
  - Required: `err_step`, `level`=8, `dir`=UP.
  - Stimulus: then 300 alternating 0x0000/0xFFFF samples.
  - Required: `err_count` saturates at 255.
  - Stimulus: then `clr`=1 for one cycle.
  - Required: `err_count`=0.
- **Reset mid-sweep**
  - Stimulus: assert `rst_n`=0 at level 9 going UP; release with `LEDs`=0x01FF.
  - Required: after reset, all outputs 0 and IDLE.
  - Required: first sample gives `err_step`, `level`=9, `dir`=UP.
